// File: rtl/elevator_pkg.sv
// Shared encodings for the three-floor elevator controller: motor commands,
// floor codes (also the display code), FSM states and travel direction.
package elevator_pkg;

   localparam logic [1:0] AC_STOP = 2'b00;
   localparam logic [1:0] AC_UP   = 2'b01;
   localparam logic [1:0] AC_DOWN = 2'b10;

   localparam logic [1:0] FLOOR1 = 2'b01;
   localparam logic [1:0] FLOOR2 = 2'b10;
   localparam logic [1:0] FLOOR3 = 2'b11;

   localparam int DOOR_CYCLES_DEF = 3;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

   // Bit 0 = floor 1, bit 2 = floor 3.
   function automatic logic [2:0] floor_oh(input logic [1:0] f);
      case (f)
         FLOOR2:  return 3'b010;
         FLOOR3:  return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

endpackage

// File: rtl/elevator_controller_pulse_catcher.sv
// Catches an asynchronous pulse of any width and turns it into a single
// clk-cycle event: toggle on the pulse edge, two-flop sync, edge detect.
module pulse_catcher (
   input  logic clk,
   input  logic rst,
   input  logic pulse,
   output logic evt
);

   logic       tgl;
   logic [2:0] sync;

   always_ff @(posedge pulse or negedge rst) begin
      if (!rst) tgl <= 1'b0;
      else      tgl <= ~tgl;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync <= '0;
      else      sync <= {sync[1:0], tgl};
   end

   assign evt = sync[1] ^ sync[2];

endmodule

// File: rtl/elevator_controller.sv
// Three-floor collective (SCAN) elevator controller: latches hall and car
// calls, tracks the cab floor from sensors and sequences motor and door.
module elevator_controller
   import elevator_pkg::*;
#(
   parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s1, s2, s3,
   input  logic       f1, f2, f3,
   input  logic       u1, u2, u3,
   input  logic       d1, d2, d3,
   output logic [1:0] ac,
   output logic [1:0] display,
   output logic       doorOpen
);

   localparam int CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CYCLES - 1);

   logic [11:0]   raw, ev;
   logic [2:0]    ev_car, ev_up, ev_dn, ev_sen;
   logic [2:0]    car, up, dn;
   logic [2:0]    car_e, up_e, dn_e, any_e;
   logic [2:0]    cur_oh, above, below;
   logic [2:0]    clr_car, clr_up, clr_dn;
   logic [1:0]    floor, floor_now;
   logic          req_above, req_below, req_here, sensor_hit, ahead, restart;
   logic [CW-1:0] cnt;
   state_t        state;
   dir_t          dir;

   assign raw = {d3, d2, d1, u3, u2, u1, f3, f2, f1, s3, s2, s1};

   for (genvar i = 0; i < 12; i++) begin : g_catch
      pulse_catcher u_pc (.clk(clk), .rst(rst), .pulse(raw[i]), .evt(ev[i]));
   end

   // u3 and d1 have no direction at an end floor, so they act as plain calls.
   assign ev_sen = ev[2:0];
   assign ev_car = {ev[5] | ev[8], ev[4], ev[3] | ev[9]};
   assign ev_up  = {1'b0, ev[7], ev[6]};
   assign ev_dn  = {ev[11], ev[10], 1'b0};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      floor_now = floor;
      if      (ev_sen[0]) floor_now = FLOOR1;
      else if (ev_sen[1]) floor_now = FLOOR2;
      else if (ev_sen[2]) floor_now = FLOOR3;
      sensor_hit = |ev_sen;
      cur_oh     = floor_oh(floor_now);
      above      = cur_oh[0] ? 3'b110 : (cur_oh[1] ? 3'b100 : 3'b000);
      below      = cur_oh[2] ? 3'b011 : (cur_oh[1] ? 3'b001 : 3'b000);

      // Events merge with pending flags so a same-cycle call is seen at once.
      car_e     = car | ev_car;
      up_e      = up  | ev_up;
      dn_e      = dn  | ev_dn;
      any_e     = car_e | up_e | dn_e;
      req_above = |(any_e & above);
      req_below = |(any_e & below);
      req_here  = |(any_e & cur_oh);

      ahead   = 1'b0;
      clr_car = '0;
      clr_up  = '0;
      clr_dn  = '0;
      if (state == DOOR) begin
         ahead   = (dir == DIR_UP && req_above) || (dir == DIR_DOWN && req_below);
         clr_car = cur_oh;
         clr_up  = (ahead && dir == DIR_DOWN) ? 3'b000 : cur_oh;
         clr_dn  = (ahead && dir == DIR_UP)   ? 3'b000 : cur_oh;
      end
      restart = |((ev_car & clr_car) | (ev_up & clr_up) | (ev_dn & clr_dn));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         car <= '0;
         up  <= '0;
         dn  <= '0;
      end else begin
         car <= car_e & ~clr_car;
         up  <= up_e  & ~clr_up;
         dn  <= dn_e  & ~clr_dn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         floor   <= FLOOR1;
         display <= FLOOR1;
      end else begin
         floor   <= floor_now;
         display <= floor;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         dir      <= DIR_NONE;
         ac       <= AC_STOP;
         doorOpen <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_here) begin
                  state    <= DOOR;
                  dir      <= DIR_NONE;
                  doorOpen <= 1'b1;
                  cnt      <= CNT_LOAD;
               end else if (req_above) begin
                  state <= MOVE_UP;
                  dir   <= DIR_UP;
                  ac    <= AC_UP;
               end else if (req_below) begin
                  state <= MOVE_DOWN;
                  dir   <= DIR_DOWN;
                  ac    <= AC_DOWN;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (sensor_hit &&
                   ((state == MOVE_UP   && (|(cur_oh & (car_e | up_e)) || !req_above)) ||
                    (state == MOVE_DOWN && (|(cur_oh & (car_e | dn_e)) || !req_below)))) begin
                  state    <= DOOR;
                  ac       <= AC_STOP;
                  doorOpen <= 1'b1;
                  cnt      <= CNT_LOAD;
               end
            end
            DOOR: begin
               if (restart) begin
                  cnt <= CNT_LOAD;
               end else if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  doorOpen <= 1'b0;
                  if ((ahead && dir == DIR_UP) || (!ahead && req_above)) begin
                     state <= MOVE_UP;
                     dir   <= DIR_UP;
                     ac    <= AC_UP;
                  end else if (ahead || req_below) begin
                     state <= MOVE_DOWN;
                     dir   <= DIR_DOWN;
                     ac    <= AC_DOWN;
                  end else begin
                     state <= IDLE;
                     dir   <= DIR_NONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller: short async button/sensor pulses,
// outputs sampled on the falling clk edge against hand-derived values.
module tb_elevator_controller;

   localparam int S1 = 0, S2 = 1, S3 = 2;
   localparam int F1 = 3, F2 = 4, F3 = 5;
   localparam int U1 = 6, U2 = 7, U3 = 8;
   localparam int D1 = 9, D2 = 10, D3 = 11;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] btn = '0;
   logic [1:0]  ac, display;
   logic        doorOpen;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   elevator_controller #(.DOOR_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .s1(btn[S1]), .s2(btn[S2]), .s3(btn[S3]),
      .f1(btn[F1]), .f2(btn[F2]), .f3(btn[F3]),
      .u1(btn[U1]), .u2(btn[U2]), .u3(btn[U3]),
      .d1(btn[D1]), .d2(btn[D2]), .d3(btn[D3]),
      .ac(ac), .display(display), .doorOpen(doorOpen)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 1 ns pulse on one or two inputs, launched just after a falling edge.
   task automatic pulse2(input int i, input int j);
      @(negedge clk);
      #1;
      btn[i] = 1'b1;
      btn[j] = 1'b1;
      #1;
      btn[i] = 1'b0;
      btn[j] = 1'b0;
   endtask

   task automatic pulse(input int i);
      pulse2(i, i);
   endtask

   initial begin
      cyc(2);
      check("rst_ac", 8'(ac), 8'h0);
      check("rst_display", 8'(display), 8'h1);
      check("rst_door", 8'(doorOpen), 8'h0);
      rst = 1'b1;
      cyc(1);

      // Floor 1 -> 2 on a hall up-call.
      pulse(U2);
      cyc(2);
      check("u2_not_yet", 8'(ac), 8'h0);
      cyc(1);
      check("u2_ac_up", 8'(ac), 8'h1);
      pulse(S2);
      cyc(3);
      check("s2_stop_ac", 8'(ac), 8'h0);
      check("s2_door_c1", 8'(doorOpen), 8'h1);
      cyc(1);
      check("s2_display", 8'(display), 8'h2);
      check("s2_door_c2", 8'(doorOpen), 8'h1);
      cyc(1);
      check("s2_door_c3", 8'(doorOpen), 8'h1);
      cyc(1);
      check("s2_door_closed", 8'(doorOpen), 8'h0);
      check("s2_idle_ac", 8'(ac), 8'h0);
      cyc(3);
      check("u2_cleared", 8'(ac), 8'h0);

      // Floor 2 -> 3 -> 1, passing floor 2 without a stop.
      pulse(U3);
      cyc(3);
      check("u3_ac_up", 8'(ac), 8'h1);
      pulse(S3);
      cyc(3);
      check("s3_door", 8'(doorOpen), 8'h1);
      check("s3_ac_stop", 8'(ac), 8'h0);
      cyc(1);
      check("s3_display", 8'(display), 8'h3);
      cyc(2);
      check("s3_door_closed", 8'(doorOpen), 8'h0);
      check("s3_idle", 8'(ac), 8'h0);
      pulse(F1);
      cyc(3);
      check("f1_ac_down", 8'(ac), 8'h2);
      pulse(S2);
      cyc(3);
      check("s2_pass_ac", 8'(ac), 8'h2);
      check("s2_pass_door", 8'(doorOpen), 8'h0);
      cyc(1);
      check("s2_pass_display", 8'(display), 8'h2);
      pulse(S1);
      cyc(3);
      check("s1_stop_ac", 8'(ac), 8'h0);
      check("s1_door", 8'(doorOpen), 8'h1);
      cyc(1);
      check("s1_display", 8'(display), 8'h1);
      cyc(2);
      check("s1_door_closed", 8'(doorOpen), 8'h0);

      // Call at the current floor while idle opens the door without motion.
      pulse(F1);
      cyc(3);
      check("f1_here_door", 8'(doorOpen), 8'h1);
      check("f1_here_ac", 8'(ac), 8'h0);
      cyc(3);
      check("f1_here_closed", 8'(doorOpen), 8'h0);
      check("f1_here_idle", 8'(ac), 8'h0);

      // Down-call at 3 with an up-call at 2 picked up on the way.
      pulse(D3);
      cyc(3);
      check("d3_ac_up", 8'(ac), 8'h1);
      pulse(U2);
      cyc(3);
      check("u2_moving_ac", 8'(ac), 8'h1);
      pulse(S2);
      cyc(3);
      check("u2_stop_door", 8'(doorOpen), 8'h1);
      check("u2_stop_ac", 8'(ac), 8'h0);
      cyc(3);
      check("u2_resume_up", 8'(ac), 8'h1);
      check("u2_resume_door", 8'(doorOpen), 8'h0);
      pulse(S3);
      cyc(3);
      check("d3_door", 8'(doorOpen), 8'h1);
      cyc(3);
      check("d3_door_closed", 8'(doorOpen), 8'h0);
      cyc(4);
      check("d3_cleared", 8'(ac), 8'h0);

      // Back to floor 2, then a tie: u1 and f3 together go up first.
      pulse(F2);
      cyc(3);
      check("f2_ac_down", 8'(ac), 8'h2);
      pulse(S2);
      cyc(3);
      check("f2_door", 8'(doorOpen), 8'h1);
      cyc(3);
      check("f2_idle", 8'(ac), 8'h0);
      pulse2(U1, F3);
      cyc(3);
      check("tie_up", 8'(ac), 8'h1);
      pulse(S3);
      cyc(3);
      check("tie_s3_door", 8'(doorOpen), 8'h1);
      cyc(3);
      check("tie_reverse", 8'(ac), 8'h2);
      pulse(S2);
      cyc(3);
      check("tie_s2_pass", 8'(ac), 8'h2);
      pulse(S1);
      cyc(3);
      check("tie_s1_door", 8'(doorOpen), 8'h1);
      cyc(3);
      check("tie_s1_idle", 8'(ac), 8'h0);

      // Reset mid-motion with d3 pending; pulse during reset is dropped.
      pulse(D3);
      cyc(3);
      check("mid_ac_up", 8'(ac), 8'h1);
      pulse(S2);
      cyc(4);
      check("mid_display", 8'(display), 8'h2);
      check("mid_still_up", 8'(ac), 8'h1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_ac", 8'(ac), 8'h0);
      check("rst_mid_display", 8'(display), 8'h1);
      check("rst_mid_door", 8'(doorOpen), 8'h0);
      pulse(D3);
      cyc(1);
      rst = 1'b1;
      cyc(6);
      check("post_rst_ac", 8'(ac), 8'h0);
      check("post_rst_door", 8'(doorOpen), 8'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
